// File: rtl/matvec_fp_seq.sv
// Serial single-precision matrix-vector engine: C = A*B (or A^T*B) using one
// shared external multiplier and one shared external adder over stb/ack handshakes.
module matvec_fp_seq #(
  parameter int DIM   = 4,
  parameter int IDX_W = $clog2(DIM)
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        data_valid,
  input  logic [31:0] data,
  output logic        data_ready,
  input  logic        reuse_a,
  input  logic        transpose,
  output logic [31:0] mul_data_a,
  output logic [31:0] mul_data_b,
  output logic        mul_a_stb,
  output logic        mul_b_stb,
  input  logic        mul_a_ack,
  input  logic        mul_b_ack,
  input  logic [31:0] mul_result,
  input  logic        mul_z_stb,
  output logic        mul_z_ack,
  output logic [31:0] add_data_a,
  output logic [31:0] add_data_b,
  output logic        add_a_stb,
  output logic        add_b_stb,
  input  logic        add_a_ack,
  input  logic        add_b_ack,
  input  logic [31:0] add_result,
  input  logic        add_z_stb,
  output logic        add_z_ack,
  output logic [31:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        result_last,
  output logic        busy,
  output logic        done
);

  localparam int AW = $clog2(DIM * DIM);
  localparam int CW = $clog2(DIM * DIM + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CW-1:0]    A_LAST   = CW'(DIM * DIM - 1);
  localparam logic [CW-1:0]    B_LAST   = CW'(DIM - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_MUL    = 3'd3,
    S_ADD    = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  // Each MUL/ADD step: present operands, wait for both operand acks, wait for z.
  typedef enum logic [1:0] {
    PH_ISSUE = 2'd0,
    PH_ACK   = 2'd1,
    PH_Z     = 2'd2
  } phase_t;

  state_t           r_state;
  phase_t           r_phase;
  logic [CW-1:0]    r_cnt;
  logic [IDX_W-1:0] r_i;
  logic [IDX_W-1:0] r_k;
  logic [IDX_W-1:0] r_j;
  logic             r_a_stored;
  logic             r_transpose;
  logic [31:0]      r_acc;
  logic [31:0]      r_prod;
  logic [31:0]      r_a [DIM*DIM];
  logic [31:0]      r_b [DIM];
  logic [31:0]      r_c [DIM];

  logic w_accept;

  assign data_ready = !iRst && (r_state == S_IDLE || r_state == S_LOAD_A || r_state == S_LOAD_B);
  assign w_accept   = data_valid && data_ready;
  assign busy       = (r_state != S_IDLE);

  function automatic logic [31:0] f_a_elem(input logic [IDX_W-1:0] row, input logic [IDX_W-1:0] col);
    logic [AW-1:0] idx;
    if (r_transpose) idx = AW'(col) * AW'(DIM) + AW'(row);
    else             idx = AW'(row) * AW'(DIM) + AW'(col);
    return r_a[idx];
  endfunction

  // Main sequencer: load, serial multiply/accumulate per row, then stream C out.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state      <= S_IDLE;
      r_phase      <= PH_ISSUE;
      r_cnt        <= '0;
      r_i          <= '0;
      r_k          <= '0;
      r_j          <= '0;
      r_a_stored   <= 1'b0;
      r_transpose  <= 1'b0;
      r_acc        <= 32'd0;
      r_prod       <= 32'd0;
      mul_data_a   <= 32'd0;
      mul_data_b   <= 32'd0;
      mul_a_stb    <= 1'b0;
      mul_b_stb    <= 1'b0;
      mul_z_ack    <= 1'b0;
      add_data_a   <= 32'd0;
      add_data_b   <= 32'd0;
      add_a_stb    <= 1'b0;
      add_b_stb    <= 1'b0;
      add_z_ack    <= 1'b0;
      result       <= 32'd0;
      result_valid <= 1'b0;
      result_last  <= 1'b0;
      done         <= 1'b0;
    end else begin
      mul_z_ack <= 1'b0;
      add_z_ack <= 1'b0;
      done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_transpose <= transpose;
            r_cnt       <= CNT_ONE;
            if (reuse_a && r_a_stored) begin
              r_b[0]  <= data;
              r_state <= S_LOAD_B;
            end else begin
              r_a[0]     <= data;
              r_a_stored <= 1'b0;
              r_state    <= S_LOAD_A;
            end
          end
        end
        S_LOAD_A: begin
          if (w_accept) begin
            r_a[r_cnt[AW-1:0]] <= data;
            if (r_cnt == A_LAST) begin
              r_cnt      <= '0;
              r_a_stored <= 1'b1;
              r_state    <= S_LOAD_B;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        S_LOAD_B: begin
          if (w_accept) begin
            r_b[r_cnt[IDX_W-1:0]] <= data;
            if (r_cnt == B_LAST) begin
              r_cnt   <= '0;
              r_i     <= '0;
              r_k     <= '0;
              r_phase <= PH_ISSUE;
              r_state <= S_MUL;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        S_MUL: begin
          case (r_phase)
            PH_ISSUE: begin
              mul_data_a <= f_a_elem(r_i, r_k);
              mul_data_b <= r_b[r_k];
              mul_a_stb  <= 1'b1;
              mul_b_stb  <= 1'b1;
              r_phase    <= PH_ACK;
            end
            PH_ACK: begin
              if (mul_a_stb && mul_a_ack) mul_a_stb <= 1'b0;
              if (mul_b_stb && mul_b_ack) mul_b_stb <= 1'b0;
              if ((!mul_a_stb || mul_a_ack) && (!mul_b_stb || mul_b_ack)) r_phase <= PH_Z;
            end
            PH_Z: begin
              // The !mul_z_ack guard keeps a lingering z_stb from being acked twice.
              if (mul_z_stb && !mul_z_ack) begin
                mul_z_ack <= 1'b1;
                r_prod    <= mul_result;
                r_phase   <= PH_ISSUE;
                if (r_k == '0) begin
                  r_acc <= mul_result;
                  r_k   <= r_k + IDX_ONE;
                end else begin
                  r_state <= S_ADD;
                end
              end
            end
            default: r_phase <= PH_ISSUE;
          endcase
        end
        S_ADD: begin
          case (r_phase)
            PH_ISSUE: begin
              add_data_a <= r_acc;
              add_data_b <= r_prod;
              add_a_stb  <= 1'b1;
              add_b_stb  <= 1'b1;
              r_phase    <= PH_ACK;
            end
            PH_ACK: begin
              if (add_a_stb && add_a_ack) add_a_stb <= 1'b0;
              if (add_b_stb && add_b_ack) add_b_stb <= 1'b0;
              if ((!add_a_stb || add_a_ack) && (!add_b_stb || add_b_ack)) r_phase <= PH_Z;
            end
            PH_Z: begin
              if (add_z_stb && !add_z_ack) begin
                add_z_ack <= 1'b1;
                r_acc     <= add_result;
                r_phase   <= PH_ISSUE;
                if (r_k != LAST_IDX) begin
                  r_k     <= r_k + IDX_ONE;
                  r_state <= S_MUL;
                end else begin
                  r_c[r_i] <= add_result;
                  r_k      <= '0;
                  if (r_i != LAST_IDX) begin
                    r_i     <= r_i + IDX_ONE;
                    r_state <= S_MUL;
                  end else begin
                    r_j          <= '0;
                    result       <= r_c[0];
                    result_valid <= 1'b1;
                    result_last  <= 1'b0;
                    r_state      <= S_OUT;
                  end
                end
              end
            end
            default: r_phase <= PH_ISSUE;
          endcase
        end
        S_OUT: begin
          if (result_valid && result_ready) begin
            if (r_j != LAST_IDX) begin
              r_j         <= r_j + IDX_ONE;
              result      <= r_c[r_j + IDX_ONE];
              result_last <= ((r_j + IDX_ONE) == LAST_IDX);
            end else begin
              result_valid <= 1'b0;
              result_last  <= 1'b0;
              done         <= 1'b1;
              r_state      <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_fp_seq.sv
// Directed bench for matvec_fp_seq with behavioural FP multiplier/adder models
// that handle the small positive integer values used by the vectors.
module tb_matvec_fp_seq;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        data_valid;
  logic [31:0] data;
  logic        data_ready;
  logic        reuse_a;
  logic        transpose;
  logic [31:0] mul_data_a, mul_data_b, add_data_a, add_data_b;
  logic        mul_a_stb, mul_b_stb, add_a_stb, add_b_stb;
  logic        mul_a_ack = 1'b0, mul_b_ack = 1'b0, add_a_ack = 1'b0, add_b_ack = 1'b0;
  logic [31:0] mul_result = 32'd0, add_result = 32'd0;
  logic        mul_z_stb = 1'b0, add_z_stb = 1'b0;
  logic        mul_z_ack, add_z_ack;
  logic [31:0] result;
  logic        result_valid, result_ready, result_last, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int lat_max = 0;
  int acc_cnt = 0, done_cnt = 0, mulz_cnt = 0, zack_err = 0;
  logic prev_mza = 1'b0, prev_aza = 1'b0;

  logic [31:0] rowv  [4];
  logic [31:0] exp_c [4];

  always #5 iClk = ~iClk;

  matvec_fp_seq #(.DIM(4)) dut (
    .iClk(iClk), .iRst(iRst),
    .data_valid(data_valid), .data(data), .data_ready(data_ready),
    .reuse_a(reuse_a), .transpose(transpose),
    .mul_data_a(mul_data_a), .mul_data_b(mul_data_b),
    .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
    .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
    .mul_result(mul_result), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
    .add_data_a(add_data_a), .add_data_b(add_data_b),
    .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
    .add_a_ack(add_a_ack), .add_b_ack(add_b_ack),
    .add_result(add_result), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .result_last(result_last), .busy(busy), .done(done)
  );

  function automatic int f2i(input logic [31:0] f);
    int e;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    return int'({8'd0, 1'b1, f[22:0]} >> (23 - e));
  endfunction

  function automatic logic [31:0] i2f(input int v);
    int p;
    logic [31:0] m;
    if (v <= 0) return 32'd0;
    p = 0;
    for (int b = 0; b < 31; b++) if (v[b]) p = b;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Multiplier model: independent random operand-ack delays, then random z delay.
  logic ma_got = 1'b0, mb_got = 1'b0;
  logic [31:0] ma_v = 32'd0, mb_v = 32'd0;
  int ma_dly = 0, mb_dly = 0, mz_dly = 0;
  always @(posedge iClk) begin
    if (iRst) begin
      mul_a_ack <= 1'b0; mul_b_ack <= 1'b0; mul_z_stb <= 1'b0;
      ma_got <= 1'b0; mb_got <= 1'b0; ma_dly <= 0; mb_dly <= 0; mz_dly <= 0;
    end else begin
      mul_a_ack <= 1'b0;
      mul_b_ack <= 1'b0;
      if (mul_a_stb && !mul_a_ack && !ma_got) begin
        if (ma_dly == 0) begin
          mul_a_ack <= 1'b1; ma_v <= mul_data_a; ma_got <= 1'b1;
          ma_dly <= int'($urandom_range(0, lat_max));
        end else ma_dly <= ma_dly - 1;
      end
      if (mul_b_stb && !mul_b_ack && !mb_got) begin
        if (mb_dly == 0) begin
          mul_b_ack <= 1'b1; mb_v <= mul_data_b; mb_got <= 1'b1;
          mb_dly <= int'($urandom_range(0, lat_max));
        end else mb_dly <= mb_dly - 1;
      end
      if (ma_got && mb_got && !mul_z_stb) begin
        if (mz_dly == 0) begin
          mul_z_stb  <= 1'b1;
          mul_result <= i2f(f2i(ma_v) * f2i(mb_v));
        end else mz_dly <= mz_dly - 1;
      end
      if (mul_z_stb && mul_z_ack) begin
        mul_z_stb <= 1'b0; ma_got <= 1'b0; mb_got <= 1'b0;
        mz_dly <= int'($urandom_range(0, lat_max));
      end
    end
  end

  // Adder model, same handshake behaviour as the multiplier.
  logic aa_got = 1'b0, ab_got = 1'b0;
  logic [31:0] aa_v = 32'd0, ab_v = 32'd0;
  int aa_dly = 0, ab_dly = 0, az_dly = 0;
  always @(posedge iClk) begin
    if (iRst) begin
      add_a_ack <= 1'b0; add_b_ack <= 1'b0; add_z_stb <= 1'b0;
      aa_got <= 1'b0; ab_got <= 1'b0; aa_dly <= 0; ab_dly <= 0; az_dly <= 0;
    end else begin
      add_a_ack <= 1'b0;
      add_b_ack <= 1'b0;
      if (add_a_stb && !add_a_ack && !aa_got) begin
        if (aa_dly == 0) begin
          add_a_ack <= 1'b1; aa_v <= add_data_a; aa_got <= 1'b1;
          aa_dly <= int'($urandom_range(0, lat_max));
        end else aa_dly <= aa_dly - 1;
      end
      if (add_b_stb && !add_b_ack && !ab_got) begin
        if (ab_dly == 0) begin
          add_b_ack <= 1'b1; ab_v <= add_data_b; ab_got <= 1'b1;
          ab_dly <= int'($urandom_range(0, lat_max));
        end else ab_dly <= ab_dly - 1;
      end
      if (aa_got && ab_got && !add_z_stb) begin
        if (az_dly == 0) begin
          add_z_stb  <= 1'b1;
          add_result <= i2f(f2i(aa_v) + f2i(ab_v));
        end else az_dly <= az_dly - 1;
      end
      if (add_z_stb && add_z_ack) begin
        add_z_stb <= 1'b0; aa_got <= 1'b0; ab_got <= 1'b0;
        az_dly <= int'($urandom_range(0, lat_max));
      end
    end
  end

  // Event counters and z_ack pulse-width monitor.
  always @(posedge iClk) begin
    if (data_valid && data_ready) acc_cnt <= acc_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mul_z_ack) mulz_cnt <= mulz_cnt + 1;
    if ((mul_z_ack && prev_mza) || (add_z_ack && prev_aza)) zack_err <= zack_err + 1;
    prev_mza <= mul_z_ack;
    prev_aza <= add_z_ack;
  end

  task automatic set_exp(input logic [31:0] c0, input logic [31:0] c1,
                         input logic [31:0] c2, input logic [31:0] c3);
    exp_c[0] = c0; exp_c[1] = c1; exp_c[2] = c2; exp_c[3] = c3;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {22'd0, busy, done, result_valid, result_last, mul_a_stb, mul_b_stb,
                          mul_z_ack, add_a_stb, add_b_stb, add_z_ack}, 32'd0);
    check({tag, "_data"}, result | mul_data_a | mul_data_b | add_data_a | add_data_b, 32'd0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic ra, input logic tr);
    int n;
    n = 0;
    data = w; data_valid = 1'b1; reuse_a = ra; transpose = tr;
    while (!data_ready && n < 3000) begin @(negedge iClk); n++; end
    if (n >= 3000) check("send_timeout", 32'd1, 32'd0);
    @(negedge iClk);
    data_valid = 1'b0;
  endtask

  task automatic send_stream(input logic ra, input logic tr, input logic send_a, input logic [31:0] bval);
    int nw;
    logic [31:0] v;
    nw = send_a ? 20 : 4;
    for (int w = 0; w < nw; w++) begin
      if (send_a && w < 16) v = rowv[w / 4];
      else                  v = bval;
      send_word(v, ra, tr);
    end
  endtask

  task automatic collect(input int hold);
    int n;
    int unst;
    logic [31:0] v0;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      while (!result_valid && n < 3000) begin @(negedge iClk); n++; end
      if (n >= 3000) begin
        check("res_timeout", 32'(j), 32'hFFFF_FFFF);
        result_ready = 1'b0;
        return;
      end
      if (hold > 0) begin
        result_ready = 1'b0;
        v0 = result;
        unst = 0;
        repeat (hold) begin
          @(negedge iClk);
          if (result !== v0 || result_valid !== 1'b1) unst++;
        end
        check("res_hold", 32'(unst), 32'd0);
      end
      check($sformatf("res%0d", j), result, exp_c[j]);
      check($sformatf("last%0d", j), {31'd0, result_last}, {31'd0, (j == 3)});
      result_ready = 1'b1;
      @(negedge iClk);
    end
    result_ready = 1'b0;
  endtask

  task automatic run_job(input logic ra, input logic tr, input logic send_a,
                         input logic [31:0] bval, input int hold, input int exp_words);
    int b_acc;
    int b_done;
    b_acc  = acc_cnt;
    b_done = done_cnt;
    send_stream(ra, tr, send_a, bval);
    check("words_accepted", 32'(acc_cnt - b_acc), 32'(exp_words));
    check("ready_after_load", {31'd0, data_ready}, 32'd0);
    collect(hold);
    repeat (2) @(negedge iClk);
    check("done_pulses", 32'(done_cnt - b_done), 32'd1);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int b_mz;
    rowv[0] = 32'h3F80_0000; rowv[1] = 32'h4000_0000;
    rowv[2] = 32'h4040_0000; rowv[3] = 32'h4080_0000;
    iRst = 1'b1; data_valid = 1'b0; data = 32'd0; reuse_a = 1'b0; transpose = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(negedge iClk);
    check("rst_ready_low", {31'd0, data_ready}, 32'd0);
    check_reset_outputs("rst");
    iRst = 1'b0;
    @(negedge iClk);
    check("idle_ready", {31'd0, data_ready}, 32'd1);

    // reuse_a with nothing stored behaves as a full load
    set_exp(32'h4080_0000, 32'h4100_0000, 32'h4140_0000, 32'h4180_0000);
    run_job(1'b1, 1'b0, 1'b1, 32'h3F80_0000, 0, 20);

    set_exp(32'h4120_0000, 32'h4120_0000, 32'h4120_0000, 32'h4120_0000);
    run_job(1'b0, 1'b1, 1'b1, 32'h3F80_0000, 0, 20);

    set_exp(32'h4100_0000, 32'h4180_0000, 32'h41C0_0000, 32'h4200_0000);
    run_job(1'b1, 1'b0, 1'b0, 32'h4000_0000, 0, 4);

    set_exp(32'h4080_0000, 32'h4100_0000, 32'h4140_0000, 32'h4180_0000);
    run_job(1'b0, 1'b0, 1'b1, 32'h3F80_0000, 5, 20);

    lat_max = 7;
    run_job(1'b0, 1'b0, 1'b1, 32'h3F80_0000, 0, 20);

    // Reset in the middle of row 2's multiplies
    lat_max = 3;
    b_mz = mulz_cnt;
    send_stream(1'b0, 1'b0, 1'b1, 32'h3F80_0000);
    n = 0;
    while (mulz_cnt < b_mz + 9 && n < 3000) begin @(negedge iClk); n++; end
    check("row2_reached", {31'd0, (n < 3000)}, 32'd1);
    iRst = 1'b1;
    @(negedge iClk);
    check("midrst_ready_low", {31'd0, data_ready}, 32'd0);
    check_reset_outputs("midrst");
    iRst = 1'b0;
    @(negedge iClk);
    run_job(1'b1, 1'b0, 1'b1, 32'h3F80_0000, 0, 20);

    check("z_ack_width", 32'(zack_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
